// File: rtl/mult_share_arb_if.sv
// Request/response bus between the requesters, the consumer and mult_share_arb.
interface mult_share_arb_if #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned ACC_W = 10,
    parameter int unsigned ID_W  = (NREQ > 1) ? $clog2(NREQ) : 1
);
    logic [NREQ-1:0]          req_valid;
    logic [NREQ-1:0]          req_ready;
    logic [3*NREQ-1:0]        req_a;
    logic [3*NREQ-1:0]        req_b;
    logic [NREQ-1:0]          req_acc;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [ID_W-1:0]          rsp_id;
    logic signed [5:0]        rsp_prod;
    logic signed [ACC_W-1:0]  rsp_acc;

    // Requester/consumer side
    modport master (
        output req_valid, req_a, req_b, req_acc, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_prod, rsp_acc
    );

    // Arbiter side
    modport slave (
        input  req_valid, req_a, req_b, req_acc, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_prod, rsp_acc
    );
endinterface

// File: rtl/mult_share_arb.sv
// Round-robin arbiter sharing one 3x3 signed multiplier among NREQ requesters,
// each with its own saturating signed accumulator.

// Exact 3x3 two's-complement multiplier (library cell).
module mult_share_arb_mul3 (
    input  logic signed [2:0] a_i,
    input  logic signed [2:0] b_i,
    output logic signed [5:0] p_o
);
    logic signed [5:0] a_x;
    logic signed [5:0] b_x;

    // Sign-extend to the product width so the multiply is exact
    always_comb begin
        a_x = {{3{a_i[2]}}, a_i};
        b_x = {{3{b_i[2]}}, b_i};
        p_o = a_x * b_x;
    end
endmodule

module mult_share_arb #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned ACC_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    mult_share_arb_if.slave  bus
);
    localparam int unsigned ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic [ID_W-1:0]          last_q, last_d;
    logic                     rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]          rsp_id_q, rsp_id_d;
    logic signed [5:0]        rsp_prod_q, rsp_prod_d;
    logic signed [ACC_W-1:0]  rsp_acc_q, rsp_acc_d;
    logic signed [ACC_W-1:0]  acc_q [NREQ];
    logic signed [ACC_W-1:0]  acc_d [NREQ];

    logic                     can_accept_c;
    logic [NREQ-1:0]          grant_c;
    logic [ID_W-1:0]          gidx_c;
    logic                     found_c;
    logic                     accept_c;
    int unsigned              scan_idx;
    logic signed [2:0]        op_a_c;
    logic signed [2:0]        op_b_c;
    logic signed [5:0]        prod_c;
    logic signed [ACC_W-1:0]  prod_x_c;
    logic signed [ACC_W-1:0]  acc_sel_c;
    logic signed [ACC_W:0]    sum_c;
    logic signed [ACC_W-1:0]  acc_new_c;

    assign can_accept_c = !rsp_valid_q || bus.rsp_ready;

    // Round-robin search starting one past the last grant; gated by reset
    always_comb begin
        grant_c  = '0;
        gidx_c   = '0;
        found_c  = 1'b0;
        scan_idx = 0;
        for (int k = 0; k < int'(NREQ); k++) begin
            scan_idx = (int'(last_q) + 1 + k) % NREQ;
            if (!found_c && bus.req_valid[scan_idx]) begin
                found_c = 1'b1;
                gidx_c  = ID_W'(scan_idx);
            end
        end
        if (found_c && can_accept_c && rst_n) begin
            grant_c[gidx_c] = 1'b1;
        end
    end

    assign accept_c = |grant_c;

    // Operands come straight from the granted requester's slices
    always_comb begin
        op_a_c = bus.req_a[3*int'(gidx_c) +: 3];
        op_b_c = bus.req_b[3*int'(gidx_c) +: 3];
    end

    mult_share_arb_mul3 u_mul (
        .a_i (op_a_c),
        .b_i (op_b_c),
        .p_o (prod_c)
    );

    // Accumulate-or-load with saturation on signed overflow
    always_comb begin
        prod_x_c  = {{(ACC_W-6){prod_c[5]}}, prod_c};
        acc_sel_c = acc_q[gidx_c];
        sum_c     = {acc_sel_c[ACC_W-1], acc_sel_c} + {prod_x_c[ACC_W-1], prod_x_c};
        if (!bus.req_acc[gidx_c]) begin
            acc_new_c = prod_x_c;
        end else if (sum_c[ACC_W] != sum_c[ACC_W-1]) begin
            acc_new_c = sum_c[ACC_W] ? ACC_MIN : ACC_MAX;
        end else begin
            acc_new_c = sum_c[ACC_W-1:0];
        end
    end

    // Next state: load response on accept, drop valid when consumed
    always_comb begin
        last_d      = last_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_prod_d  = rsp_prod_q;
        rsp_acc_d   = rsp_acc_q;
        for (int i = 0; i < int'(NREQ); i++) begin
            acc_d[i] = acc_q[i];
        end
        if (accept_c) begin
            last_d         = gidx_c;
            rsp_valid_d    = 1'b1;
            rsp_id_d       = gidx_c;
            rsp_prod_d     = prod_c;
            rsp_acc_d      = acc_new_c;
            acc_d[gidx_c]  = acc_new_c;
        end else if (bus.rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q      <= ID_W'(NREQ - 1);
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_prod_q  <= '0;
            rsp_acc_q   <= '0;
            for (int i = 0; i < int'(NREQ); i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            last_q      <= last_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_prod_q  <= rsp_prod_d;
            rsp_acc_q   <= rsp_acc_d;
            for (int i = 0; i < int'(NREQ); i++) begin
                acc_q[i] <= acc_d[i];
            end
        end
    end

    assign bus.req_ready = grant_c;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_prod  = rsp_prod_q;
    assign bus.rsp_acc   = rsp_acc_q;
endmodule
